pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, number of pipeline stages (carry-chain segments); WIDTH SHALL be an integer multiple of STAGES, and 1 <= STAGES <= WIDTH.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  0: a+b+cin; 1: a-b, computed as a + ~b + 1.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of MSB; for sub=1, 1 means no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-017 The carry chain SHALL be split into STAGES segments of WIDTH/STAGES bits; segment k (LSB first) SHALL be evaluated in pipeline stage k using the carry registered from stage k-1.
REQ-018 Upper operand segments SHALL be skewed (delayed) and lower sum segments de-skewed so all bits of one result emerge together.
REQ-019 Global advance condition: adv = !out_valid || out_ready; all pipeline registers and per-stage valid bits SHALL update only when adv=1.
REQ-020 in_ready SHALL equal adv; a beat is accepted iff in_valid && in_ready.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stall occurs; throughput one result per cycle.
REQ-022 While out_valid && !out_ready, sum, cout, ovf and out_valid SHALL hold stable.
REQ-023 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid stages and never produce out_valid.
REQ-024 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-025 ovf SHALL be 1 iff operand-A sign equals effective-B sign (b for add, ~b for sub) and result sign differs.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH for sum; carry beyond MSB appears only on cout.
REQ-027 Per-beat sub and cin SHALL travel with their beat; changing sub between consecutive beats SHALL not affect in-flight beats.
REQ-028 STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 On rst=1, all stage valid bits, out_valid, sum, cout and ovf SHALL clear to 0 immediately, independent of clk.
REQ-030 In-flight beats at reset SHALL be discarded; in_ready SHALL be 1 while rst=1 and after release.
REQ-031 First beat accepted after rst deasserts SHALL appear after exactly STAGES cycles.

Configuration
REQ-032 Macro PIPELINED_ADDER_SAT_EN SHALL select saturating mode when defined.
REQ-033 With PIPELINED_ADDER_SAT_EN defined, when ovf=1 sum SHALL clamp to signed max (0x7FF..F) if A non-negative, else signed min (0x800..0); ovf and cout still report unsaturated values.
REQ-034 Without PIPELINED_ADDER_SAT_EN, sum SHALL wrap per REQ-026 and no clamp logic SHALL be present.

Verification (WIDTH=32, STAGES=4)
REQ-035 a=0x0000FFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> after 4 cycles sum=0x00010000, cout=0, ovf=0 (carry crosses segment boundary).
REQ-036 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0; a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0.
REQ-037 a=0x7FFFFFFF, b=1, sub=0 -> ovf=1; sum=0x80000000 without macro, 0x7FFFFFFF with PIPELINED_ADDER_SAT_EN.
REQ-038 Back-to-back 8 beats, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs stable, all 8 results in order, none lost.
REQ-039 Random valid/ready toggling, 10k beats vs. reference model -> all results match, correct order.
REQ-040 rst asserted with 3 beats in flight -> out_valid=0 immediately, no stale result appears after release.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Carry chain split into STAGES registered segments with a single global stall (valid/ready).
// Define PIPELINED_ADDER_SAT_EN to clamp sum to signed max/min on overflow; default wraps.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a, w_b, w_s, w_s_next;
    logic             w_c, w_v;
    logic [SEG:0]     w_seg;
    logic [WIDTH-1:0] r_a, r_b, r_s;
    logic             r_c, r_v;

    // Stage 0 folds subtraction into the operand: b is inverted and the carry-in forced to 1.
    if (k == 0) begin : g_head
      assign w_a = bus.a;
      assign w_b = bus.sub ? ~bus.b : bus.b;
      assign w_c = bus.sub | bus.cin;
      assign w_s = '0;
      assign w_v = bus.in_valid;
    end else begin : g_body
      assign w_a = g_stage[k-1].r_a;
      assign w_b = g_stage[k-1].r_b;
      assign w_c = g_stage[k-1].r_c;
      assign w_s = g_stage[k-1].r_s;
      assign w_v = g_stage[k-1].r_v;
    end

    always_comb begin
      w_seg = {1'b0, w_a[k*SEG +: SEG]} + {1'b0, w_b[k*SEG +: SEG]} + {{SEG{1'b0}}, w_c};
      w_s_next = w_s;
      w_s_next[k*SEG +: SEG] = w_seg[SEG-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_seg[SEG];
        r_a <= w_a;
        r_b <= w_b;
        r_s <= w_s_next;
      end
    end
  end

  assign w_adv        = !g_stage[LAST].r_v || bus.out_ready;
  assign bus.in_ready = w_adv;

  logic [WIDTH-1:0] w_raw;
  logic             w_a_sign, w_b_sign, w_ovf;

  // Effective-b sign comes from the already-inverted operand carried down the pipe.
  assign w_raw    = g_stage[LAST].r_s;
  assign w_a_sign = g_stage[LAST].r_a[WIDTH-1];
  assign w_b_sign = g_stage[LAST].r_b[WIDTH-1];
  assign w_ovf    = (w_a_sign == w_b_sign) && (w_raw[WIDTH-1] != w_a_sign);

  assign bus.out_valid = g_stage[LAST].r_v;
  assign bus.cout      = g_stage[LAST].r_c;
  assign bus.ovf       = w_ovf;

`ifdef PIPELINED_ADDER_SAT_EN
  assign bus.sum = !w_ovf   ? w_raw :
                   w_a_sign ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign bus.sum = w_raw;
`endif
endmodule
